// File: rtl/alu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   muldiv_op_t    - request operation codes (M-extension encoding order)
//   muldiv_state_t - control FSM states
//   muldiv_class_t - datapath iteration kind (shift-add vs restoring subtract)
//   MULDIV_ITERS   - iterations per operation (one per operand bit)
//   DIV0_QUOT      - quotient returned for division by zero
package alu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_t;

  typedef enum logic {
    CLS_MUL = 1'b0,
    CLS_DIV = 1'b1
  } muldiv_class_t;

  localparam int          MULDIV_ITERS = 32;
  localparam logic [31:0] DIV0_QUOT    = 32'hFFFFFFFF;

  // All divide/remainder codes have bit 2 set.
  function automatic muldiv_class_t op_class(input muldiv_op_t op);
    return op[2] ? CLS_DIV : CLS_MUL;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration of the multiply/divide loop (purely combinational).
//   acc      - {hi, lo} working register (2*WIDTH bits)
//   operand  - multiplicand / divisor magnitude (WIDTH+1 bits)
//   op_class - CLS_MUL: conditional add of operand into hi, then shift right
//              CLS_DIV: shift left, trial-subtract operand, set quotient bit
//   acc_next - updated working register
// Divide layout: hi holds the partial remainder, lo shifts the dividend out
// at the top while quotient bits enter at the bottom.
module muldiv_step
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH:0]     operand,
  input  muldiv_class_t      op_class,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  always_comb begin
    // Multiply: the carry out of the add lands in the top bit after the shift.
    add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? operand : '0);

    // Divide: remainder stays below the divisor, so WIDTH bits always hold
    // whichever of trial / diff is kept; the borrow decides which.
    trial  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    borrow = (trial < operand);
    diff   = trial[WIDTH-1:0] - operand[WIDTH-1:0];

    if (op_class == CLS_MUL) begin
      acc_next = {add_sum, acc[WIDTH-1:1]};
    end else begin
      acc_next = {(borrow ? trial[WIDTH-1:0] : diff), acc[WIDTH-2:0], ~borrow};
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative 32-bit multiply/divide unit (M-extension ops beside the ALU).
//   clk, rst_n            - clock, asynchronous active-low reset
//   req_valid/req_ready   - request handshake; req_ready is high only in IDLE
//   req_op, req_a, req_b  - operation code and operands, sampled on accept
//   rsp_valid/rsp_ready   - response handshake; rsp_valid is high only in DONE
//   rsp_result            - registered result, stable while rsp_valid is high
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both high; ready never depends combinationally on valid.
// Latency: accept on edge k, 32 iterations on edges k+1..k+32, result
// registered on edge k+33, which is also where rsp_valid rises.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result
);

  localparam logic [5:0] ITER_LAST = 6'(MULDIV_ITERS);

  muldiv_state_t      state_q, state_d;
  muldiv_op_t         op_in, op_q;
  logic [5:0]         iter_q;
  logic [2*WIDTH-1:0] acc_q, acc_step;
  logic [WIDTH:0]     b_mag_q;
  logic [WIDTH-1:0]   a_raw_q;
  logic               neg_q, b_zero_q;
  logic [WIDTH-1:0]   rsp_result_q;

  // Request decode: operand signedness, magnitudes and result sign.
  logic             signed_a, signed_b, a_neg, b_neg, res_neg_d;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH:0]   b_abs;

  always_comb begin
    op_in    = muldiv_op_t'(req_op);
    signed_a = (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
               (op_in == OP_DIV)  || (op_in == OP_REM);
    signed_b = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
    a_neg    = signed_a & req_a[WIDTH-1];
    b_neg    = signed_b & req_b[WIDTH-1];
    // -2^31 negates to itself, which read as unsigned is the right magnitude.
    a_abs    = a_neg ? -req_a : req_a;
    b_abs    = {1'b0, (b_neg ? -req_b : req_b)};
    // Remainder follows the dividend; everything else is the sign product.
    res_neg_d = (op_in == OP_REM) ? a_neg : (a_neg ^ b_neg);
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc_q),
    .operand  (b_mag_q),
    .op_class (op_class(op_q)),
    .acc_next (acc_step)
  );

  // Sign fixup and result selection. The overflow case (-2^31 / -1) needs no
  // special handling: the positive quotient 2^31 truncates to 0x80000000 and
  // the remainder is 0.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix, result_d;

  always_comb begin
    prod_fix = neg_q ? -acc_q : acc_q;
    quot_fix = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    result_d = '0;
    case (op_q)
      OP_MUL:                      result_d = prod_fix[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result_d = prod_fix[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:             result_d = b_zero_q ? DIV0_QUOT : quot_fix;
      OP_REM, OP_REMU:             result_d = b_zero_q ? a_raw_q : rem_fix;
      default:                     result_d = '0;
    endcase
  end

  // Control FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_valid)            state_d = ST_CALC;
      ST_CALC: if (iter_q == ITER_LAST)  state_d = ST_DONE;
      ST_DONE: if (rsp_ready)            state_d = ST_IDLE;
      default:                           state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_MUL;
      iter_q       <= '0;
      acc_q        <= '0;
      b_mag_q      <= '0;
      a_raw_q      <= '0;
      neg_q        <= 1'b0;
      b_zero_q     <= 1'b0;
      rsp_result_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            op_q     <= op_in;
            acc_q    <= {{WIDTH{1'b0}}, a_abs};
            b_mag_q  <= b_abs;
            a_raw_q  <= req_a;
            neg_q    <= res_neg_d;
            b_zero_q <= (req_b == '0);
            iter_q   <= '0;
          end
        end
        ST_CALC: begin
          // Counter reaching ITER_LAST means the loop is finished and this
          // edge only registers the fixed-up result.
          if (iter_q != ITER_LAST) begin
            acc_q  <= acc_step;
            iter_q <= iter_q + 6'd1;
          end else begin
            rsp_result_q <= result_d;
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign rsp_valid  = (state_q == ST_DONE);
  assign rsp_result = rsp_result_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: directed vectors with hand-computed
// results, scoreboard queue filled at accept, monitor popping on response.
module tb_alu_muldiv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_result;

  logic [31:0] exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          failures = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  alu_muldiv #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result)
  );

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out", name);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp: actual=0x%08h required=none", rsp_result);
      end else begin
        logic [31:0] e;
        string       n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        check(n, rsp_result, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Issue one request, optionally registering its expected result, and
  // return after the accept edge (+1).
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input string name, input bit push);
    int n = 0;
    while (!req_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!req_ready) flag({name, "_req_ready"});
    req_valid = 1'b1;
    req_op = op;
    req_a = a;
    req_b = b;
    @(posedge clk);
    if (push) begin
      exp_q.push_back(exp);
      name_q.push_back(name);
    end
    #1;
    req_valid = 1'b0;
    // Inputs are don't-care once accepted.
    req_op = 3'($urandom_range(0, 7));
    req_a = $urandom;
    req_b = $urandom;
  endtask

  // Count edges from accept until rsp_valid is seen; expected 33.
  task automatic wait_rsp(input string name);
    int lat = 0;
    while (!rsp_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    check({name, "_latency"}, 32'(lat), 32'd33);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (exp_q.size() != 0) flag({name, "_drain"});
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string name);
    issue(op, a, b, exp, name, 1'b1);
    wait_rsp(name);
    drain(name);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs.push_back('{3'd0, 32'd7,          32'd6,          32'd42,         "mul_7x6"});
    vecs.push_back('{3'd3, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE,   "mulhu_max"});
    vecs.push_back('{3'd1, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'h00000000,   "mulh_m1xm1"});
    vecs.push_back('{3'd2, 32'hFFFFFFFF,   32'd2,          32'hFFFFFFFF,   "mulhsu_m1x2"});
    vecs.push_back('{3'd1, 32'h80000000,   32'h80000000,   32'h40000000,   "mulh_min2"});
    vecs.push_back('{3'd0, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   "mul_min_x_max"});
    vecs.push_back('{3'd4, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   "div_m7_2"});
    vecs.push_back('{3'd6, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   "rem_m7_2"});
    vecs.push_back('{3'd4, 32'd20,         32'hFFFFFFFD,   32'hFFFFFFFA,   "div_20_m3"});
    vecs.push_back('{3'd6, 32'd20,         32'hFFFFFFFD,   32'd2,          "rem_20_m3"});
    vecs.push_back('{3'd5, 32'd100,        32'd7,          32'd14,         "divu_100_7"});
    vecs.push_back('{3'd7, 32'd100,        32'd7,          32'd2,          "remu_100_7"});
    vecs.push_back('{3'd4, 32'd5,          32'd0,          32'hFFFFFFFF,   "div_by0"});
    vecs.push_back('{3'd6, 32'd5,          32'd0,          32'd5,          "rem_by0"});
    vecs.push_back('{3'd5, 32'd5,          32'd0,          32'hFFFFFFFF,   "divu_by0"});
    vecs.push_back('{3'd7, 32'h80000007,   32'd0,          32'h80000007,   "remu_by0"});
    vecs.push_back('{3'd4, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   "div_ovf"});
    vecs.push_back('{3'd6, 32'h80000000,   32'hFFFFFFFF,   32'h00000000,   "rem_ovf"});
  end

  // ---------------- main sequence ----------------
  initial begin
    // Reset and idle.
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_result", rsp_result, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_req_ready", 32'(req_ready), 32'd1);
    check("idle_rsp_valid", 32'(rsp_valid), 32'd0);

    // Directed functional vectors.
    foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);

    // Backpressure: hold the response, offer a competing request meanwhile.
    rsp_ready = 1'b0;
    issue(3'd5, 32'd100, 32'd7, 32'd14, "bp_divu", 1'b1);
    wait_rsp("bp_divu");
    req_valid = 1'b1;
    req_op = 3'd0;
    req_a = 32'd5;
    req_b = 32'd5;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_result_hold", rsp_result, 32'd14);
      check("bp_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("bp_release_req_ready", 32'(req_ready), 32'd1);
    check("bp_pending", 32'(exp_q.size()), 32'd0);
    repeat (40) @(posedge clk);
    #1;
    check("bp_no_extra_rsp", 32'(rsp_valid), 32'd0);

    // Reset in the middle of CALC discards the operation.
    issue(3'd0, 32'd1234, 32'd5678, 32'd0, "abort_mul", 1'b0);
    repeat (15) @(posedge clk);
    #1;
    check("mid_busy_req_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_req_ready", 32'(req_ready), 32'd1);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_rsp_result", rsp_result, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(3'd0, 32'd3, 32'd3, 32'd9, "post_rst_mul_3x3");

    repeat (5) @(posedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Iterative 32-bit multiply/divide unit that sits beside the single-cycle ALU in the execute stage and services the M-extension operations the ALU does not implement. It accepts one operation at a time through a valid/ready request port. It computes the result with a radix-2 shift-add / restoring-divide loop and returns it on a valid/ready response port. The pipeline control stalls on `req_ready` / `rsp_valid`.

## Interface
Parameters:
- `WIDTH`, 32: operand/result width; only 32 is supported and verified.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request.
- `req_op`  in  3  operation code (`muldiv_op_t`).
- `req_a`  in  32  operand A (multiplicand / dividend).
- `req_b`  in  32  operand B (multiplier / divisor).
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer takes result.
- `rsp_result`  out  32  result word.

## Operation
- Op codes:
  - 0 MUL: low 32 bits of the product.
  - 1 MULH: high 32 bits, signed×signed.
  - 2 MULHSU: high 32 bits, signed×unsigned.
  - 3 MULHU: high 32 bits, unsigned×unsigned.
  - 4 DIV: signed quotient.
  - 5 DIVU: unsigned quotient.
  - 6 REM: signed remainder.
  - 7 REMU: unsigned remainder.
- States:
  - IDLE → CALC when the request handshake fires.
  - CALC → DONE after the 32nd iteration.
  - DONE → IDLE when the response handshake fires.
- On accept, latch op, |A|, |B| (for signed ops), the result-sign flags, and clear the 6-bit iteration counter.
- Multiply: 64-bit accumulator with one shift-add per CALC cycle. The product is negated at the end if the sign flag is set.
- Divide: restoring algorithm, one quotient bit per CALC cycle. The quotient sign is sign(A) XOR sign(B). The remainder takes the sign of A.
- Divide by zero:
  - DIV/DIVU return 0xFFFFFFFF.
  - REM/REMU return A unchanged.
  - The loop still runs; the result mux overrides it.
- Signed overflow, 0x80000000 / 0xFFFFFFFF:
  - DIV returns 0x80000000.
  - REM returns 0.
- Width rules:
  - Magnitudes are held in 33 bits, so |−2^31| is representable.
  - The accumulator is 64 bits, plus 1 bit for the subtract borrow.
- `rsp_result` is registered and stable while `rsp_valid` is high.

## Timing
- Reset values:
  - state = IDLE, `req_ready` = 1, `rsp_valid` = 0, `rsp_result` = 0.
  - Counter and all datapath registers = 0.
- `req_ready` is 1 only in IDLE. It is a function of state only, with no combinational path from `req_valid`.
- The request is accepted on the edge where `req_valid` and `req_ready` are both 1 (edge k).
- Fixed latency for all ops, including divide by zero: CALC occupies edges k+1 … k+32. `rsp_valid` rises after edge k+33.
- `rsp_valid` holds, with `rsp_result` unchanged, until a cycle with `rsp_ready` = 1. The unit returns to IDLE on that edge, and `req_ready` = 1 in the following cycle.
- No request/response overlap: minimum issue interval is 35 cycles at full throughput.
- `req_*` inputs are ignored outside IDLE. Changes to them during CALC or DONE have no effect.
- `rst_n` low in any state immediately returns all outputs to their reset values. Any in-flight operation is discarded and no response is produced for it.

## Structure
- Package `alu_pkg` holds:
  - the `muldiv_op_t` enum (the 8 codes above);
  - the state enum (IDLE, CALC, DONE);
  - the constants `MULDIV_ITERS` = 32 and `DIV0_QUOT` = 32'hFFFFFFFF.
- Natural sub-module: `muldiv_step`, purely combinational. It performs one shift-add or restoring-subtract iteration on {acc, operand, op class}. It is instantiated once in the CALC datapath.
- The FSM, counter, sign fixup and result mux stay in `alu_muldiv`.

## Test plan
- Reset and idle:
  - Assert `rst_n` low, then release.
  - Required: `req_ready` = 1, `rsp_valid` = 0, `rsp_result` = 0.
- MUL and unsigned high product:
  - MUL A = 7, B = 6 → `rsp_result` = 42, with `rsp_valid` exactly 33 cycles after the accept edge.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULH 0xFFFFFFFF×0xFFFFFFFF → 0.
- Signed divide:
  - DIV A = 0xFFFFFFF9 (−7), B = 2 → 0xFFFFFFFD (−3).
  - REM with the same operands → 0xFFFFFFFF (−1).
  - DIVU 100 / 7 → 14.
  - REMU 100 / 7 → 2.
- Corner cases:
  - DIV 5 / 0 → 0xFFFFFFFF.
  - REM 5 / 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM with the same operands → 0.
- Backpressure:
  - Hold `rsp_ready` = 0 for 10 cycles after `rsp_valid`.
  - Required: result held stable, `req_ready` = 0 throughout, and a new request driven meanwhile is not accepted.
- Reset mid-operation:
  - Assert `rst_n` at cycle 15 of CALC.
  - Required: outputs return to their reset values immediately.
  - After release, MUL 3×3 → 9 with normal latency.
